// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one 2-input adder among NUM_REQ requesters.
// Optional grant counter enabled by defining ADDER_ARB_STATS_EN.
module adder_2_inputs #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  assign {carry, sum} = a + b;
endmodule

module adder_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [15:0]              grant_count
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;

  logic              can_accept;
  logic              gnt_found;
  logic              grant;
  logic [ID_W-1:0]   gnt_idx;
  int                idx;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [WIDTH-1:0]  add_sum;
  logic              add_carry;

  always_comb begin
    can_accept = (state_q == EMPTY) || rsp_ready;
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(idx);
      end
    end
    // reset gates the grant so nothing is handed out during reset
    grant     = can_accept && gnt_found && !rst;
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  assign op_a = req_a[gnt_idx*WIDTH +: WIDTH];
  assign op_b = req_b[gnt_idx*WIDTH +: WIDTH];

  adder_2_inputs #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a     (op_a),
    .b     (op_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    unique case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL:  if (!grant && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (grant) begin
      rsp_id_d     = gnt_idx;
      rsp_result_d = add_sum;
      rsp_carry_d  = add_carry;
      rr_ptr_d     = (NUM_REQ > 1) ?
                     ID_W'((int'(gnt_idx) + 1) % NUM_REQ) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      rr_ptr_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] grant_count_q, grant_count_d;

  always_comb begin
    grant_count_d = grant_count_q;
    if (grant && grant_count_q != 16'hFFFF)
      grant_count_d = grant_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) grant_count_q <= '0;
    else     grant_count_q <= grant_count_d;
  end

  assign grant_count = grant_count_q;
`endif

endmodule
